// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package muldiv_pkg;

   // One iteration per result bit
   localparam int ITER_COUNT = 32;
   localparam int CNT_W      = 6;

   // op[1] selects divide, op[0] selects unsigned
   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is
   // the correct unsigned magnitude
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operation request, MTHI/MTLO write and HI/LO result bundle.
// Latency: n/a (wiring only).
// Backpressure: requests while busy are dropped by the controller.
interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
      input  busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
      output busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_addsub.sv
// 33-bit adder/subtractor shared by the shift-add and shift-subtract loops.
// Latency: combinational.
// Backpressure: none.
module muldiv_addsub (
   input  logic [32:0] i_a,
   input  logic [32:0] i_b,
   input  logic        i_sub,
   output logic [32:0] o_sum,
   output logic        o_cout
);

   logic [32:0] w_b_eff;

   // Subtract as a + ~b + 1; carry-out high means no borrow (a >= b)
   always_comb begin
      w_b_eff          = i_sub ? ~i_b : i_b;
      {o_cout, o_sum}  = {1'b0, i_a} + {1'b0, w_b_eff} + {33'd0, i_sub};
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative 32x32 multiply / 32/32 divide with architectural HI/LO.
// Latency: 33 busy cycles per operation, done pulses the cycle after.
// Backpressure: start is ignored while busy; the CPU stalls on busy.
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   muldiv_if.slave   bus
);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opd;
   op_e         r_op;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;
   logic        r_dz;

   op_e         w_op;
   logic        w_is_div;
   logic        w_is_signed;
   logic [31:0] w_mag_rs;
   logic [31:0] w_mag_rt;
   logic        w_accept;
   logic        w_dz_start;
   logic        w_last;

   logic [32:0] w_as_a;
   logic [32:0] w_as_b;
   logic        w_as_sub;
   logic [32:0] w_as_sum;
   logic        w_as_cout;
   logic [63:0] w_acc_step;

   logic        w_fix_neg_q;
   logic        w_fix_neg_r;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;
   logic [31:0] w_res_hi;
   logic [31:0] w_res_lo;

   // Decode the incoming request
   always_comb begin
      w_op        = op_e'(bus.op);
      w_is_div    = w_op[1];
      w_is_signed = ~w_op[0];
      w_mag_rs    = abs32(bus.rs_val, w_is_signed);
      w_mag_rt    = abs32(bus.rt_val, w_is_signed);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-cycle control strobes
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_dz_start  = 1'b0;
      w_last      = (r_cnt == CNT_W'(ITER_COUNT - 1));
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               if (w_is_div && (bus.rt_val == 32'd0)) begin
                  // Divide by zero is reported without ever going busy
                  w_dz_start = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (w_last) begin
               w_state_nxt = ST_FIX;
            end
         end
         ST_FIX: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Select adder operands for the current algorithm
   always_comb begin
      w_as_sub = r_op[1];
      w_as_b   = {1'b0, r_opd};
      if (r_op[1]) begin
         // Partial remainder shifted left by one, 33 bits wide
         w_as_a = r_acc[63:31];
      end else begin
         w_as_a = {1'b0, r_acc[63:32]};
      end
   end

   muldiv_addsub u_addsub (
      .i_a    (w_as_a),
      .i_b    (w_as_b),
      .i_sub  (w_as_sub),
      .o_sum  (w_as_sum),
      .o_cout (w_as_cout)
   );

   // One iteration: acc holds {upper half, multiplier/quotient bits}
   always_comb begin
      if (r_op[1]) begin
         // Restoring divide: keep the difference only when it did not borrow
         w_acc_step = w_as_cout ? {w_as_sum[31:0], r_acc[30:0], 1'b1}
                                : {r_acc[62:0], 1'b0};
      end else begin
         // Shift-add multiply: the 33rd sum bit becomes the new MSB
         w_acc_step = r_acc[0] ? {w_as_sum, r_acc[31:1]}
                               : {1'b0, r_acc[63:1]};
      end
   end

   // Sign correction applied in FIX
   always_comb begin
      w_fix_neg_q = r_neg_q & ~r_op[0];
      w_fix_neg_r = r_neg_r & ~r_op[0];
      w_prod      = w_fix_neg_q ? (~r_acc + 64'd1) : r_acc;
      w_quo       = w_fix_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      w_rem       = w_fix_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
      if (r_op[1]) begin
         w_res_hi = w_rem;
         w_res_lo = w_quo;
      end else begin
         w_res_hi = w_prod[63:32];
         w_res_lo = w_prod[31:0];
      end
   end

   // Working registers: load magnitudes at accept, iterate in CALC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opd   <= '0;
         r_op    <= OP_MULT;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_acc   <= {32'd0, (w_is_div ? w_mag_rs : w_mag_rt)};
         r_opd   <= w_is_div ? w_mag_rt : w_mag_rs;
         r_op    <= w_op;
         r_neg_q <= bus.rs_val[31] ^ bus.rt_val[31];
         r_neg_r <= bus.rs_val[31];
      end else if (r_state == ST_CALC) begin
         r_cnt   <= r_cnt + CNT_W'(1);
         r_acc   <= w_acc_step;
      end
   end

   // HI/LO: MTHI/MTLO only while idle, result write in FIX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == ST_IDLE) begin
         if (bus.hi_we) begin
            r_hi <= bus.wdata;
         end
         if (bus.lo_we) begin
            r_lo <= bus.wdata;
         end
      end else if (r_state == ST_FIX) begin
         r_hi <= w_res_hi;
         r_lo <= w_res_lo;
      end
   end

   // Completion pulse and sticky divide-by-zero flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
      end else begin
         r_done <= (r_state == ST_FIX) | w_dz_start;
         if (w_dz_start) begin
            r_dz <= 1'b1;
         end else if (w_accept) begin
            r_dz <= 1'b0;
         end
      end
   end

   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.done     = r_done;
   assign bus.div_zero = r_dz;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl using a result scoreboard.
module tb_muldiv_ctrl;

   logic clk = 1'b0;
   logic rst;

   muldiv_if bus ();

   muldiv_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_hi     = '0;
   logic [31:0] m_lo     = '0;

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [31:0] cur_hi,
                                  input logic [31:0] cur_lo);
      exp_t        e;
      logic [63:0] p;
      longint      a, b, q, r;
      e.hi = cur_hi;
      e.lo = cur_lo;
      e.dz = 1'b0;
      case (op)
         2'b00: begin
            p = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b01: begin
            p = {32'd0, rs} * {32'd0, rt};
            e.hi = p[63:32];
            e.lo = p[31:0];
         end
         2'b10: begin
            if (rt == 32'd0) begin
               e.dz = 1'b1;
            end else begin
               a = longint'($signed(rs));
               b = longint'($signed(rt));
               q = a / b;
               r = a % b;
               p = q;
               e.lo = p[31:0];
               p = r;
               e.hi = p[31:0];
            end
         end
         default: begin
            if (rt == 32'd0) begin
               e.dz = 1'b1;
            end else begin
               e.lo = rs / rt;
               e.hi = rs % rt;
            end
         end
      endcase
      return e;
   endfunction

   // Issue one operation, optionally with a same-cycle MTHI/MTLO and an
   // illegal start/MT write injected at busy cycle 'inject'.
   task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic mt_same, input int inject, input string name);
      exp_t e;
      int   busy_cnt;
      bit   seen;
      @(negedge clk);
      bus.op     = op;
      bus.rs_val = rs;
      bus.rt_val = rt;
      bus.start  = 1'b1;
      if (mt_same) begin
         bus.hi_we = 1'b1;
         bus.lo_we = 1'b1;
         bus.wdata = 32'hA5A5_0F0F;
         m_hi = 32'hA5A5_0F0F;
         m_lo = 32'hA5A5_0F0F;
      end
      sb.push_back(model(op, rs, rt, m_hi, m_lo));
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.hi_we  = 1'b0;
      bus.lo_we  = 1'b0;
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      bus.op     = 2'($urandom_range(3));
      if (mt_same) begin
         checks++;
         if (bus.hi !== 32'hA5A5_0F0F || bus.lo !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL %s mt_same_cycle: hi=%h lo=%h required %h", name, bus.hi, bus.lo,
                     32'hA5A5_0F0F);
         end
      end
      busy_cnt = 0;
      seen     = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
         bus.lo_we = 1'b0;
         if (bus.done) begin
            seen = 1'b1;
            checks++;
            if (bus.busy !== 1'b0) begin
               failures++;
               $display("FAIL %s busy_at_done: busy=%b required 0", name, bus.busy);
            end
         end else if (bus.busy) begin
            busy_cnt++;
         end
         if (c == inject) begin
            bus.start  = 1'b1;
            bus.op     = 2'b11;
            bus.rt_val = 32'd0;
            bus.hi_we  = 1'b1;
            bus.lo_we  = 1'b1;
            bus.wdata  = 32'hDEAD_BEEF;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s done_timeout: no done within 60 cycles", name);
         void'(sb.pop_front());
         return;
      end
      e = sb.pop_front();
      checks++;
      if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_zero !== e.dz) begin
         failures++;
         $display("FAIL %s result: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                  name, bus.hi, bus.lo, bus.div_zero, e.hi, e.lo, e.dz);
      end
      checks++;
      if (busy_cnt !== (e.dz ? 0 : 33)) begin
         failures++;
         $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, e.dz ? 0 : 33);
      end
      m_hi = e.hi;
      m_lo = e.lo;
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         failures++;
         $display("FAIL %s done_width: done=%b required 0 one cycle later", name, bus.done);
      end
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.op     = 2'b00;
      bus.rs_val = '0;
      bus.rt_val = '0;
      bus.hi_we  = 1'b0;
      bus.lo_we  = 1'b0;
      bus.wdata  = '0;
      #12;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 ||
          bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: busy=%b done=%b dz=%b hi=%h lo=%h required all 0",
                  bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mt_write(input logic [31:0] hv, input logic [31:0] lv);
      @(negedge clk);
      bus.hi_we = 1'b1;
      bus.wdata = hv;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b1;
      bus.wdata = lv;
      @(negedge clk);
      bus.lo_we = 1'b0;
      m_hi = hv;
      m_lo = lv;
      checks++;
      if (bus.hi !== hv || bus.lo !== lv) begin
         failures++;
         $display("FAIL mt_write: hi=%h lo=%h required %h %h", bus.hi, bus.lo, hv, lv);
      end
   endtask

   task automatic test_spec_vectors();
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, -1, "mult_neg");
      checks++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFF1) begin
         failures++;
         $display("FAIL mult_neg_const: hi=%h lo=%h required ffffffff fffffff1", bus.hi, bus.lo);
      end
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, "multu_max");
      checks++;
      if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
         failures++;
         $display("FAIL multu_max_const: hi=%h lo=%h required fffffffe 00000001", bus.hi, bus.lo);
      end
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, "div_neg");
      checks++;
      if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFD) begin
         failures++;
         $display("FAIL div_neg_const: hi=%h lo=%h required ffffffff fffffffd", bus.hi, bus.lo);
      end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, "div_wrap");
      checks++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'h8000_0000) begin
         failures++;
         $display("FAIL div_wrap_const: hi=%h lo=%h required 00000000 80000000", bus.hi, bus.lo);
      end
   endtask

   task automatic test_div_zero();
      test_mt_write(32'h1234_5678, 32'h1234_5678);
      run_op(2'b11, 32'd100, 32'd0, 1'b0, -1, "divu_zero");
      checks++;
      if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h1234_5678 || bus.div_zero !== 1'b1) begin
         failures++;
         $display("FAIL divu_zero_const: hi=%h lo=%h dz=%b required 12345678 12345678 1",
                  bus.hi, bus.lo, bus.div_zero);
      end
      // Next accepted non-zero operation clears the sticky flag
      run_op(2'b11, 32'd100, 32'd7, 1'b0, -1, "dz_clear");
   endtask

   task automatic test_busy_ignore();
      run_op(2'b00, 32'h0000_1234, 32'hFFFF_0000, 1'b0, 5, "start_hiwe_while_busy");
      run_op(2'b01, 32'd7, 32'd9, 1'b1, -1, "mt_same_cycle");
   endtask

   task automatic test_reset_mid();
      bit fired;
      @(negedge clk);
      bus.op     = 2'b01;
      bus.rs_val = 32'h0001_0000;
      bus.rt_val = 32'h0000_0300;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 ||
          bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b dz=%b required all 0",
                  bus.busy, bus.hi, bus.lo, bus.done, bus.div_zero);
      end
      @(negedge clk);
      rst   = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      fired = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.done || bus.busy) fired = 1'b1;
      end
      checks++;
      if (fired || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_abort: activity=%b hi=%h lo=%h required 0 0 0", fired, bus.hi, bus.lo);
      end
   endtask

   task automatic test_random();
      logic [31:0] rs, rt;
      logic [1:0]  op;
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(3));
         rs = $urandom;
         rt = $urandom;
         case ($urandom_range(5))
            0: rt = 32'd0;
            1: rt = 32'($urandom_range(15));
            2: rs = 32'h8000_0000;
            default: ;
         endcase
         run_op(op, rs, rt, 1'b0, -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_mt_write(32'hCAFE_0001, 32'hBEEF_0002);
      test_spec_vectors();
      test_div_zero();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
